// File: rtl/btn_conditioner.sv
// Push-button conditioner: per-channel 2-flop synchronizer, debouncer, and a
// press/long/repeat FSM that turns raw active-low pins into one-cycle event pulses.
module btn_conditioner #(
  parameter int unsigned NUM_BTN         = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 270000,
  parameter int unsigned LONG_CYCLES     = 13500000,
  parameter int unsigned REPEAT_CYCLES   = 5400000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_n,
  output logic [NUM_BTN-1:0] pressed,
  output logic [NUM_BTN-1:0] press_p,
  output logic [NUM_BTN-1:0] release_p,
  output logic [NUM_BTN-1:0] long_p,
  output logic [NUM_BTN-1:0] rep_p
);

  localparam int unsigned DbW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HoldMax = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int unsigned HoldW   = $clog2(HoldMax + 1);

  localparam logic [DbW-1:0]   DbLast   = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HoldW-1:0] LongLast = HoldW'(LONG_CYCLES - 1);
  localparam logic [HoldW-1:0] RepLast  = HoldW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StHeld, StRepeat} state_e;

  for (genvar i = 0; i < int'(NUM_BTN); i++) begin : g_chan
    logic             s1_q, s2_q;
    logic [DbW-1:0]   cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             flip;
    state_e           state_q, state_d;
    logic [HoldW-1:0] hold_q, hold_d;
    logic             press_q, press_d;
    logic             rel_q, rel_d;
    logic             long_q, long_d;
    logic             rep_q, rep_d;

    // Debounce: s2 is active-low, so it agrees with the accepted level when they differ.
    always_comb begin
      flip    = 1'b0;
      cnt_d   = cnt_q;
      level_d = level_q;
      if (s2_q != level_q) begin
        cnt_d = '0;
      end else if (cnt_q == DbLast) begin
        flip    = 1'b1;
        cnt_d   = '0;
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      long_d  = 1'b0;
      rep_d   = 1'b0;
      // Release wins over any long/repeat event landing on the same edge.
      if (flip && level_q) begin
        rel_d   = 1'b1;
        hold_d  = '0;
        state_d = StIdle;
      end else begin
        case (state_q)
          StIdle: begin
            if (flip) begin
              press_d = 1'b1;
              rep_d   = 1'b1;
              hold_d  = '0;
              state_d = StHeld;
            end
          end
          StHeld: begin
            if (hold_q == LongLast) begin
              long_d  = 1'b1;
              rep_d   = 1'b1;
              hold_d  = '0;
              state_d = StRepeat;
            end else begin
              hold_d = hold_q + 1'b1;
            end
          end
          StRepeat: begin
            if (hold_q == RepLast) begin
              rep_d  = 1'b1;
              hold_d = '0;
            end else begin
              hold_d = hold_q + 1'b1;
            end
          end
          default: begin
            hold_d  = '0;
            state_d = StIdle;
          end
        endcase
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1_q    <= 1'b1;
        s2_q    <= 1'b1;
        cnt_q   <= '0;
        level_q <= 1'b0;
        state_q <= StIdle;
        hold_q  <= '0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        long_q  <= 1'b0;
        rep_q   <= 1'b0;
      end else begin
        s1_q    <= btn_n[i];
        s2_q    <= s1_q;
        cnt_q   <= cnt_d;
        level_q <= level_d;
        state_q <= state_d;
        hold_q  <= hold_d;
        press_q <= press_d;
        rel_q   <= rel_d;
        long_q  <= long_d;
        rep_q   <= rep_d;
      end
    end

    assign pressed[i]   = level_q;
    assign press_p[i]   = press_q;
    assign release_p[i] = rel_q;
    assign long_p[i]    = long_q;
    assign rep_p[i]     = rep_q;
  end

endmodule
